// File: rtl/snake_state_updater_pkg.sv
// Shared constants and types for the snake state updater: grid geometry,
// tail memory depth, direction codes and the reset head cell.
package snake_state_updater_pkg;

  localparam int GRID_WIDTH  = 40;
  localparam int GRID_HEIGHT = 30;
  localparam int MAX_TAILS   = 64;
  localparam int WORD_W      = 12;
  localparam int ADDR_W      = $clog2(MAX_TAILS);

  localparam logic [WORD_W-1:0] RESET_HEAD_POS = WORD_W'(15 * GRID_WIDTH + 20);

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HEAD   = 2'b01,
    SHIFT  = 2'b10,
    COMMIT = 2'b11
  } state_t;

  // Opposite directions differ only in the upper code bit.
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return (2'(a) ^ 2'(b)) == 2'b10;
  endfunction

endpackage

// File: rtl/snake_state_updater_grid_step.sv
// One-cell move on the playfield with wrap-around at every edge.
module grid_step
  import snake_state_updater_pkg::*;
(
  input  logic [WORD_W-1:0] pos,
  input  dir_t              dir,
  output logic [WORD_W-1:0] next_pos
);

  localparam logic [WORD_W-1:0] ROW_STEP = WORD_W'(GRID_WIDTH);
  localparam logic [WORD_W-1:0] COL_SPAN = WORD_W'(GRID_WIDTH - 1);
  localparam logic [WORD_W-1:0] ROW_SPAN = WORD_W'((GRID_HEIGHT - 1) * GRID_WIDTH);

  logic [WORD_W-1:0] col;
  logic              top_row;
  logic              bottom_row;
  logic              left_col;
  logic              right_col;

  assign col        = pos % ROW_STEP;
  assign top_row    = (pos < ROW_STEP);
  assign bottom_row = (pos >= ROW_SPAN);
  assign left_col   = (col == '0);
  assign right_col  = (col == COL_SPAN);

  always_comb begin
    next_pos = pos;
    unique case (dir)
      DIR_UP:    next_pos = top_row    ? pos + ROW_SPAN : pos - ROW_STEP;
      DIR_RIGHT: next_pos = right_col  ? pos - COL_SPAN : pos + WORD_W'(1);
      DIR_DOWN:  next_pos = bottom_row ? pos - ROW_SPAN : pos + ROW_STEP;
      DIR_LEFT:  next_pos = left_col   ? pos + COL_SPAN : pos - WORD_W'(1);
      default:   next_pos = pos;
    endcase
  end

endmodule

// File: rtl/snake_state_updater.sv
// Snake move engine: on each accepted game tick computes the new head, shifts
// the tail memory one entry per cycle, detects self-collision and apple eats.
//
// state  | meaning
// IDLE   | outputs consistent, waiting for game_tick
// HEAD   | compute next head, grow flag and shift start pointer
// SHIFT  | move tail entries down one slot per cycle, check collision
// COMMIT | publish head, tail count, eat pulse and game_over
module snake_state_updater
  import snake_state_updater_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              game_tick,
  input  logic [1:0]        dir,
  input  logic [WORD_W-1:0] apple_pos,
  input  logic [ADDR_W-1:0] value_addr,
  output logic [WORD_W-1:0] cur_tail_pos,
  output logic [WORD_W-1:0] snake_head_pos,
  output logic [ADDR_W:0]   num_tails,
  output logic              calculation_finished,
  output logic              apple_eaten,
  output logic              game_over
);

  state_t            state;
  state_t            state_nx;
  dir_t              cur_dir;
  logic [WORD_W-1:0] step_pos;
  logic [WORD_W-1:0] next_head;
  logic              grow;
  logic              eat;
  logic              collision;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_start;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic              accept;

  logic              load_head;
  logic              mem_we;
  logic [WORD_W-1:0] mem_wdata;
  logic              coll_hit;
  logic              do_commit;

  logic [WORD_W-1:0] tail_mem [MAX_TAILS];

  assign accept = (state == IDLE) && game_tick && !game_over;

  grid_step u_grid_step (
    .pos      (snake_head_pos),
    .dir      (cur_dir),
    .next_pos (step_pos)
  );

  assign ptr_start = (num_tails >= (ADDR_W+1)'(MAX_TAILS - 1)) ? ADDR_W'(MAX_TAILS - 1)
                                                               : num_tails[ADDR_W-1:0];

  // The internal port always reads the entry just below the write pointer.
  assign rd_addr      = ptr - ADDR_W'(1);
  assign rd_data      = tail_mem[rd_addr];
  assign cur_tail_pos = tail_mem[value_addr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = HEAD;
      HEAD:    state_nx = SHIFT;
      SHIFT:   if (ptr == '0) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Entry rd_addr is compared as it moves; only cells still occupied after
  // this move count, so the oldest tail is skipped unless the snake grows.
  always_comb begin
    load_head = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = rd_data;
    coll_hit  = 1'b0;
    do_commit = 1'b0;
    unique case (state)
      HEAD:   load_head = 1'b1;
      SHIFT: begin
        mem_we    = 1'b1;
        mem_wdata = (ptr == '0) ? snake_head_pos : rd_data;
        coll_hit  = (ptr != '0)
                 && ({1'b0, ptr} < (num_tails + (ADDR_W+1)'(grow)))
                 && (rd_data == next_head);
      end
      COMMIT: do_commit = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_dir              <= DIR_RIGHT;
      snake_head_pos       <= RESET_HEAD_POS;
      num_tails            <= '0;
      calculation_finished <= 1'b1;
      apple_eaten          <= 1'b0;
      game_over            <= 1'b0;
      next_head            <= '0;
      grow                 <= 1'b0;
      eat                  <= 1'b0;
      collision            <= 1'b0;
      ptr                  <= '0;
    end else begin
      apple_eaten <= 1'b0;
      if (accept) begin
        calculation_finished <= 1'b0;
        collision            <= 1'b0;
        if (!is_opposite(dir_t'(dir), cur_dir)) cur_dir <= dir_t'(dir);
      end
      if (load_head) begin
        next_head <= step_pos;
        eat       <= (step_pos == apple_pos);
        grow      <= (step_pos == apple_pos) && (num_tails < (ADDR_W+1)'(MAX_TAILS));
        ptr       <= ptr_start;
      end
      if (mem_we) begin
        ptr <= ptr - ADDR_W'(1);
        if (coll_hit) collision <= 1'b1;
      end
      if (do_commit) begin
        snake_head_pos       <= next_head;
        num_tails            <= num_tails + (ADDR_W+1)'(grow);
        apple_eaten          <= eat;
        game_over            <= game_over | collision;
        calculation_finished <= 1'b1;
      end
    end
  end

  // Tail contents are intentionally not reset; num_tails qualifies them.
  always_ff @(posedge clk) begin
    if (mem_we) tail_mem[ptr] <= mem_wdata;
  end

endmodule
